// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial TX arbiter.
//   state_t   : arbiter FSM encoding (ST_IDLE=0, ST_LOCK=1)
//   NREQ_DEF  : default number of requester ports
//   TMO_W     : width of the idle-owner timeout counter / CFG_TMO
package serial_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int TMO_W    = 16;
endpackage

// File: rtl/serial_rr_pick.sv
// serial_rr_pick: combinational round-robin picker.
//   req [NREQ] : request vector
//   ptr [IDW]  : highest-priority index this round (must be < NREQ)
//   any        : at least one request present
//   idx [IDW]  : first asserted index at or after ptr, wrapping NREQ-1 -> 0
module serial_rr_pick
  import serial_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic int wrap_add(input int a, input int b);
    int s;
    s = a + b;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Scan from the farthest offset down to offset 0 so the nearest
  // request to ptr is the last (winning) assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[PW'(wrap_add(int'(ptr), i))]) begin
        any = 1'b1;
        idx = IDW'(wrap_add(int'(ptr), i));
      end
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: locks the UART TX byte stream to one requester for a
// whole message (until R_LAST), round-robin between messages.
//   CLK, RST     : clock, asynchronous active-high reset
//   R_STB/R_DATA/R_LAST/R_ACK : per-requester byte stream (8 bits each)
//   O_STB/O_DATA/O_ACK        : byte stream toward the transmitter FIFO
//   O_OWNER, O_BUSY           : current owner / lock held
//   CFG_TMO      : idle-owner timeout in cycles, 0 = off
// Build option: define SERIAL_TX_ARB_TIMEOUT_EN to release a lock whose
// owner has had R_STB low for CFG_TMO consecutive cycles; otherwise
// CFG_TMO is ignored and only R_LAST or RST releases the lock.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   R_STB,
  input  logic [8*NREQ-1:0] R_DATA,
  input  logic [NREQ-1:0]   R_LAST,
  output logic [NREQ-1:0]   R_ACK,
  output logic              O_STB,
  output logic [7:0]        O_DATA,
  input  logic              O_ACK,
  output logic [IDW-1:0]    O_OWNER,
  output logic              O_BUSY,
  input  logic [TMO_W-1:0]  CFG_TMO
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         r_state, w_state_nx;
  logic [IDW-1:0] r_owner, w_owner_nx;
  logic [IDW-1:0] r_rr_ptr, w_ptr_nx;
  logic           w_any;
  logic [IDW-1:0] w_pick;
  logic [PW-1:0]  w_own;
  logic           w_own_stb, w_own_last, w_lock;
  logic [7:0]     w_own_data;
  logic           w_tmo_hit;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] v);
    return (int'(v) >= NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  serial_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (R_STB),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  assign w_lock     = (r_state == ST_LOCK);
  assign w_own      = r_owner[PW-1:0];
  assign w_own_stb  = R_STB[w_own];
  assign w_own_last = R_LAST[w_own];
  assign w_own_data = R_DATA[{w_own, 3'b000} +: 8];

  assign O_BUSY  = w_lock;
  assign O_OWNER = r_owner;

  for (genvar k = 0; k < NREQ; k++) begin : g_ack
    assign R_ACK[k] = w_lock && (w_own == PW'(k)) && O_ACK && R_STB[k];
  end

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts consecutive owner-idle cycles; held at 0 outside LOCK so every
  // new lock starts from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     r_tmo_cnt <= '0;
    else if (!w_lock || w_own_stb) r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Only fires while the owner is idle, so a byte on offer is never dropped.
  assign w_tmo_hit = w_lock && !w_own_stb && (CFG_TMO != '0) &&
                     (r_tmo_cnt == CFG_TMO);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^CFG_TMO;
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_owner  <= w_owner_nx;
      r_rr_ptr <= w_ptr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_rr_ptr;
    O_STB      = 1'b0;
    O_DATA     = '0;
    unique case (r_state)
      // Arbitration cycle: no byte passes, the winner owns from next edge.
      ST_IDLE: begin
        if (w_any) begin
          w_state_nx = ST_LOCK;
          w_owner_nx = w_pick;
        end
      end
      ST_LOCK: begin
        O_STB  = w_own_stb;
        O_DATA = w_own_data;
        // Releasing owner drops to lowest priority for the next round.
        if ((w_own_stb && O_ACK && w_own_last) || w_tmo_hit) begin
          w_state_nx = ST_IDLE;
          w_ptr_nx   = ptr_inc(r_owner);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scoreboard bench for serial_tx_arbiter.
// Requester byte queues drive R_*; every byte expected at the output is
// pushed to a scoreboard and popped when O_STB & O_ACK is seen.
module tb_serial_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   R_STB;
  logic [8*NREQ-1:0] R_DATA;
  logic [NREQ-1:0]   R_LAST;
  logic [NREQ-1:0]   R_ACK;
  logic              O_STB;
  logic [7:0]        O_DATA;
  logic              O_ACK;
  logic [IDW-1:0]    O_OWNER;
  logic              O_BUSY;
  logic [15:0]       CFG_TMO;

  serial_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .R_STB(R_STB), .R_DATA(R_DATA), .R_LAST(R_LAST),
    .R_ACK(R_ACK), .O_STB(O_STB), .O_DATA(O_DATA), .O_ACK(O_ACK),
    .O_OWNER(O_OWNER), .O_BUSY(O_BUSY), .CFG_TMO(CFG_TMO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] k;
    logic       last;
    logic [7:0] d;
  } item_t;

  item_t       rq[$];
  logic [10:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_cnt [NREQ];
  logic        l_busy, l_stb;
  logic [7:0]  l_data;
  logic [IDW-1:0] l_owner;
  logic [NREQ-1:0] l_ack;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [7:0] d, input logic last);
    item_t it;
    it.k = k; it.d = d; it.last = last;
    rq.push_back(it);
  endtask

  task automatic expect_byte(input logic [1:0] k, input logic [7:0] d);
    sb.push_back({1'b0, k, d});
  endtask

  task automatic drive();
    logic [NREQ-1:0] seen;
    seen = '0; R_STB = '0; R_LAST = '0; R_DATA = '0;
    foreach (rq[i]) begin
      if (!seen[rq[i].k]) begin
        seen[rq[i].k] = 1'b1;
        R_STB[rq[i].k] = 1'b1;
        R_LAST[rq[i].k] = rq[i].last;
        R_DATA[{rq[i].k, 3'b000} +: 8] = rq[i].d;
      end
    end
  endtask

  task automatic pop_req(input logic [1:0] k);
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].k == k) begin
        rq.delete(i);
        break;
      end
    end
  endtask

  // One clock: sample/check at negedge, then advance requester queues on
  // the acks just seen and re-drive 1 time unit after the rising edge.
  task automatic tick();
    logic [10:0] exp;
    logic [NREQ-1:0] oh;
    @(negedge CLK);
    l_busy = O_BUSY; l_stb = O_STB; l_data = O_DATA;
    l_owner = O_OWNER; l_ack = R_ACK;
    oh = (O_STB && O_ACK) ? (NREQ'(1) << O_OWNER) : '0;
    if ((O_STB && O_ACK) || R_ACK != '0)
      check("ack_vec", 32'(R_ACK), 32'(oh));
    for (int k = 0; k < NREQ; k++) if (R_ACK[k]) ack_cnt[k]++;
    if (O_STB && O_ACK) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        exp = sb.pop_front();
        check("xfer", 32'({O_OWNER, O_DATA}), 32'(exp));
      end
    end
    @(posedge CLK); #1;
    for (int k = 0; k < NREQ; k++) if (l_ack[k]) pop_req(2'(k));
    drive();
  endtask

  task automatic clr_acks();
    for (int k = 0; k < NREQ; k++) ack_cnt[k] = 0;
  endtask

  initial begin
    RST = 1'b1; O_ACK = 1'b1; CFG_TMO = 16'd8;
    clr_acks();
    drive();
    tick();
    // Reset state
    check("rst_stb",   32'(l_stb),   32'd0);
    check("rst_busy",  32'(l_busy),  32'd0);
    check("rst_owner", 32'(l_owner), 32'd0);
    check("rst_ack",   32'(l_ack),   32'd0);
    RST = 1'b0;
    tick();

    // Contention 1011 from rr_ptr=0: order 0,1,3, one IDLE cycle between
    send(0, 8'h30, 1); send(1, 8'h31, 1); send(3, 8'h33, 1);
    expect_byte(0, 8'h30); expect_byte(1, 8'h31); expect_byte(3, 8'h33);
    drive();
    begin
      logic [6:0] pat;
      pat = 7'b0101010;
      for (int c = 0; c < 7; c++) begin
        tick();
        check("cont_busy", 32'(l_busy), 32'(pat[6-c]));
      end
    end
    check("cont_done", 32'(sb.size()), 32'd0);

    // Single requester 2: 0x41, 0x42(LAST), O_STB one cycle after request
    clr_acks();
    send(2, 8'h41, 0); send(2, 8'h42, 1);
    expect_byte(2, 8'h41); expect_byte(2, 8'h42);
    drive();
    begin
      logic [3:0] pat;
      pat = 4'b0110;
      for (int c = 0; c < 4; c++) begin
        tick();
        check("single_stb", 32'(l_stb), 32'(pat[3-c]));
      end
    end
    check("single_ack2", 32'(ack_cnt[2]), 32'd2);
    check("single_done", 32'(sb.size()), 32'd0);

    // rr_ptr is now 3: requesters 0 and 3 together -> 3 first
    send(0, 8'h50, 1); send(3, 8'h53, 1);
    expect_byte(3, 8'h53); expect_byte(0, 8'h50);
    drive();
    repeat (6) tick();
    check("rr_done", 32'(sb.size()), 32'd0);

    // Back-pressure on owner 1 during byte 2
    clr_acks();
    send(1, 8'h10, 0); send(1, 8'h11, 0); send(1, 8'h12, 1);
    expect_byte(1, 8'h10); expect_byte(1, 8'h11); expect_byte(1, 8'h12);
    drive();
    tick(); tick();
    O_ACK = 1'b0;
    repeat (5) tick();
    check("bp_hold_data", 32'(l_data), 32'h11);
    check("bp_hold_stb",  32'(l_stb),  32'd1);
    O_ACK = 1'b1;
    repeat (4) tick();
    check("bp_acks", 32'(ack_cnt[1]), 32'd3);
    check("bp_done", 32'(sb.size()), 32'd0);

    // Non-owner isolation: 0 owns, 3 requests 0xFF
    send(0, 8'hA0, 0); send(0, 8'hA1, 0); send(0, 8'hA2, 1);
    expect_byte(0, 8'hA0); expect_byte(0, 8'hA1); expect_byte(0, 8'hA2);
    expect_byte(3, 8'hFF);
    drive();
    tick();
    send(3, 8'hFF, 1);
    drive();
    O_ACK = 1'b0;
    repeat (3) begin
      tick();
      check("iso_ack3",  32'(l_ack[3]), 32'd0);
      check("iso_owner", 32'(l_owner),  32'd0);
      check("iso_data",  32'(l_data),   32'hA0);
    end
    O_ACK = 1'b1;
    repeat (8) tick();
    check("iso_done", 32'(sb.size()), 32'd0);

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    // Timeout CFG_TMO=8: owner 2 goes idle, pending 3 granted after release
    send(2, 8'hB0, 0); send(3, 8'hC0, 1);
    expect_byte(2, 8'hB0); expect_byte(3, 8'hC0);
    drive();
    tick(); tick();
    repeat (9) begin
      tick();
      check("tmo_held", 32'(l_busy), 32'd1);
    end
    tick();
    check("tmo_released", 32'(l_busy), 32'd0);
    repeat (3) tick();
    check("tmo_done", 32'(sb.size()), 32'd0);
    CFG_TMO = 16'd0;
`endif

    // Lock held indefinitely (no timeout build, or CFG_TMO=0)
    send(2, 8'hB2, 0); send(3, 8'hC1, 1);
    expect_byte(2, 8'hB2);
    drive();
    tick(); tick();
    repeat (20) tick();
    check("hold_busy",  32'(l_busy),  32'd1);
    check("hold_owner", 32'(l_owner), 32'd2);
    check("hold_sb",    32'(sb.size()), 32'd0);
    send(2, 8'hB3, 1);
    expect_byte(2, 8'hB3); expect_byte(3, 8'hC1);
    drive();
    repeat (6) tick();
    check("hold_done", 32'(sb.size()), 32'd0);

    // Reset mid-message, then index 0 wins first
    send(1, 8'hD0, 0); send(1, 8'hD1, 0); send(1, 8'hD2, 0); send(1, 8'hD3, 1);
    expect_byte(1, 8'hD0);
    drive();
    tick(); tick();
    check("mid_busy", 32'(O_BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check("arst_stb",   32'(O_STB),   32'd0);
    check("arst_busy",  32'(O_BUSY),  32'd0);
    check("arst_ack",   32'(R_ACK),   32'd0);
    check("arst_owner", 32'(O_OWNER), 32'd0);
    check("arst_sb",    32'(sb.size()), 32'd0);
    rq.delete(); sb.delete();
    drive();
    tick(); tick();
    send(1, 8'hF0, 1); send(0, 8'hE0, 1);
    expect_byte(0, 8'hE0); expect_byte(1, 8'hF0);
    drive();
    RST = 1'b0;
    repeat (6) tick();
    check("post_rst_done", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
